// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: controller for an N-way set-associative, write-back cache.
// Sequences a CPU request through tag compare, dirty-victim writeback and line
// allocation, driving the array write strobes and a burst pmem interface.
// Victim choice: first invalid way, otherwise tree-PLRU.
// Optional feature: define CACHE_CTRL_PERF_EN to build the saturating
// hit/miss/writeback counters; without it the counter outputs are tied to 0.
module cache_ctrl_nway #(
    parameter int WAYS  = 4,
    parameter int BEATS = 4,
    localparam int WB = $clog2(WAYS),
    localparam int CB = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read,
    input  logic            mem_write,
    output logic            mem_resp,
    input  logic [WAYS-1:0] hit_way,
    input  logic [WAYS-1:0] valid_way,
    input  logic [WAYS-1:0] dirty_way,
    input  logic [WAYS-2:0] plru_in,
    output logic [WAYS-2:0] plru_out,
    output logic            load_plru,
    output logic [WB-1:0]   way_sel,
    output logic            load_tag,
    output logic            load_valid,
    output logic            load_data,
    output logic            set_dirty,
    output logic            clr_dirty,
    output logic            data_in_sel,
    output logic            pmem_read,
    output logic            pmem_write,
    input  logic            pmem_resp,
    output logic [CB-1:0]   beat_cnt,
    output logic            wb_addr_sel,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count,
    output logic [31:0]     wb_count
);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    localparam logic [CB-1:0] LAST_BEAT = CB'(BEATS - 1);

    state_t          state_r, state_next_s;
    logic [WB-1:0]   victim_r, victim_s, hit_idx_s;
    logic [CB-1:0]   beat_cnt_r;
    logic            wb_done_r;
    logic            req_s, hit_any_s, victim_dirty_s, last_beat_s, beat_step_s;

    // Index of the lowest set bit (0 when none set).
    function automatic logic [WB-1:0] lowest_set(input logic [WAYS-1:0] vec);
        logic [WAYS-1:0] tmp;
        logic            found;
        logic [WB-1:0]   idx;
        tmp   = vec;
        found = 1'b0;
        idx   = {WB{1'b0}};
        for (int i = 0; i < WAYS; i++) begin
            if (!found && tmp[0]) begin
                idx   = WB'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
            tmp = tmp >> 1;
        end
        return idx;
    endfunction

    // Follow the tree bits from the root: 0 = go to the lower half, 1 = upper half.
    function automatic logic [WB-1:0] plru_victim(input logic [WAYS-2:0] bits);
        logic [WB-1:0] node;
        logic [WB-1:0] way;
        logic          dir;
        node = {WB{1'b0}};
        way  = {WB{1'b0}};
        for (int l = 0; l < WB; l++) begin
            dir  = bits[node];
            way  = (way << 1) | WB'(dir);
            node = (node << 1) + WB'(1'b1) + WB'(dir);
        end
        return way;
    endfunction

    // Point every node on the path of the touched way at the opposite half.
    function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] bits,
                                                    input logic [WB-1:0]   way);
        logic [WAYS-2:0] res;
        logic [WB-1:0]   node;
        logic [WB-1:0]   w;
        logic            dir;
        res  = bits;
        node = {WB{1'b0}};
        w    = way;
        for (int l = 0; l < WB; l++) begin
            dir       = w[WB-1];
            res[node] = ~dir;
            w         = w << 1;
            node      = (node << 1) + WB'(1'b1) + WB'(dir);
        end
        return res;
    endfunction

    // Decode request, hit way, miss victim and beat progress for the current cycle.
    always_comb begin
        req_s     = mem_read ^ mem_write;
        hit_any_s = |hit_way;
        hit_idx_s = lowest_set(hit_way);
        if (&valid_way) begin
            victim_s = plru_victim(plru_in);
        end else begin
            victim_s = lowest_set(~valid_way);
        end
        victim_dirty_s = valid_way[victim_s] & dirty_way[victim_s];
        last_beat_s    = (beat_cnt_r == LAST_BEAT);
        beat_step_s    = pmem_resp && ((state_r == ALLOCATE) ||
                                       ((state_r == WRITEBACK) && !wb_done_r));
    end

    // Next-state and strobe decode; every strobe defaults low.
    always_comb begin
        state_next_s = state_r;
        mem_resp     = 1'b0;
        plru_out     = {(WAYS-1){1'b0}};
        load_plru    = 1'b0;
        way_sel      = {WB{1'b0}};
        load_tag     = 1'b0;
        load_valid   = 1'b0;
        load_data    = 1'b0;
        set_dirty    = 1'b0;
        clr_dirty    = 1'b0;
        data_in_sel  = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        wb_addr_sel  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_next_s = COMPARE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COMPARE: begin
                if (!req_s) begin
                    // Request withdrawn during a miss: line is filled, no response.
                    state_next_s = IDLE;
                end else if (hit_any_s) begin
                    mem_resp     = 1'b1;
                    way_sel      = hit_idx_s;
                    load_plru    = 1'b1;
                    plru_out     = plru_update(plru_in, hit_idx_s);
                    if (mem_write) begin
                        load_data = 1'b1;
                        set_dirty = 1'b1;
                    end else begin
                        load_data = 1'b0;
                    end
                    state_next_s = IDLE;
                end else begin
                    way_sel = victim_s;
                    if (victim_dirty_s) begin
                        state_next_s = WRITEBACK;
                    end else begin
                        state_next_s = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                way_sel = victim_r;
                if (wb_done_r) begin
                    // Burst finished: one cycle to clear the dirty bit.
                    clr_dirty    = 1'b1;
                    state_next_s = ALLOCATE;
                end else begin
                    pmem_write  = 1'b1;
                    wb_addr_sel = 1'b1;
                end
            end
            ALLOCATE: begin
                way_sel     = victim_r;
                pmem_read   = 1'b1;
                data_in_sel = 1'b1;
                if (pmem_resp) begin
                    load_data = 1'b1;
                    if (last_beat_s) begin
                        load_tag     = 1'b1;
                        load_valid   = 1'b1;
                        clr_dirty    = 1'b1;
                        state_next_s = COMPARE;
                    end else begin
                        load_tag = 1'b0;
                    end
                end else begin
                    load_data = 1'b0;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register, victim latch, beat counter and writeback-complete flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            victim_r   <= {WB{1'b0}};
            beat_cnt_r <= {CB{1'b0}};
            wb_done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == COMPARE) &&
                ((state_next_s == WRITEBACK) || (state_next_s == ALLOCATE))) begin
                victim_r <= victim_s;
            end else begin
                victim_r <= victim_r;
            end
            if ((state_next_s != state_r) &&
                ((state_next_s == WRITEBACK) || (state_next_s == ALLOCATE))) begin
                beat_cnt_r <= {CB{1'b0}};
            end else if (beat_step_s) begin
                beat_cnt_r <= last_beat_s ? {CB{1'b0}} : beat_cnt_r + CB'(1'b1);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            wb_done_r <= (state_r == WRITEBACK) && beat_step_s && last_beat_s;
        end
    end

    assign beat_cnt = beat_cnt_r;

`ifdef CACHE_CTRL_PERF_EN
    logic [31:0] hit_count_r, miss_count_r, wb_count_r;
    logic        hit_inc_s, miss_inc_s, wb_inc_s;

    // Counter events: hit/miss on a live compare, writeback on burst entry.
    always_comb begin
        hit_inc_s  = (state_r == COMPARE) && req_s && hit_any_s;
        miss_inc_s = (state_r == COMPARE) && req_s && !hit_any_s;
        wb_inc_s   = (state_r == COMPARE) && (state_next_s == WRITEBACK);
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_r  <= 32'h0000_0000;
            miss_count_r <= 32'h0000_0000;
            wb_count_r   <= 32'h0000_0000;
        end else begin
            if (hit_inc_s && (hit_count_r != 32'hFFFF_FFFF)) begin
                hit_count_r <= hit_count_r + 32'h0000_0001;
            end else begin
                hit_count_r <= hit_count_r;
            end
            if (miss_inc_s && (miss_count_r != 32'hFFFF_FFFF)) begin
                miss_count_r <= miss_count_r + 32'h0000_0001;
            end else begin
                miss_count_r <= miss_count_r;
            end
            if (wb_inc_s && (wb_count_r != 32'hFFFF_FFFF)) begin
                wb_count_r <= wb_count_r + 32'h0000_0001;
            end else begin
                wb_count_r <= wb_count_r;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
    assign wb_count   = wb_count_r;
`else
    assign hit_count  = 32'h0000_0000;
    assign miss_count = 32'h0000_0000;
    assign wb_count   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Bench for cache_ctrl_nway (WAYS=4, BEATS=4). Expected array/pmem events are
// queued when a request is issued and compared as the controller produces them.
module tb_cache_ctrl_nway;

    localparam int EV_WB   = 0;
    localparam int EV_CLR  = 1;
    localparam int EV_FILL = 2;
    localparam int EV_RESP = 3;

    typedef struct {
        int         kind;
        int         way;
        int         aux;
        logic       flag;
        logic [2:0] plru;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, mem_resp;
    logic [3:0]  hit_way, valid_way, dirty_way;
    logic [2:0]  plru_in, plru_out;
    logic        load_plru;
    logic [1:0]  way_sel;
    logic        load_tag, load_valid, load_data, set_dirty, clr_dirty, data_in_sel;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [1:0]  beat_cnt;
    logic        wb_addr_sel;
    logic [31:0] hit_count, miss_count, wb_count;
    logic [113:0] all_out;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    cache_ctrl_nway dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way),
        .plru_in(plru_in), .plru_out(plru_out), .load_plru(load_plru),
        .way_sel(way_sel), .load_tag(load_tag), .load_valid(load_valid),
        .load_data(load_data), .set_dirty(set_dirty), .clr_dirty(clr_dirty),
        .data_in_sel(data_in_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .beat_cnt(beat_cnt), .wb_addr_sel(wb_addr_sel),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    assign all_out = {mem_resp, load_plru, plru_out, way_sel, load_tag, load_valid,
                      load_data, set_dirty, clr_dirty, data_in_sel, pmem_read,
                      pmem_write, beat_cnt, wb_addr_sel, hit_count, miss_count, wb_count};

    function automatic void push_wb(input int way);
        for (int b = 0; b < 4; b++) exp_q.push_back('{EV_WB, way, b, 1'b1, 3'b000});
        exp_q.push_back('{EV_CLR, way, 0, 1'b0, 3'b000});
    endfunction

    function automatic void push_fill(input int way);
        for (int b = 0; b < 4; b++) exp_q.push_back('{EV_FILL, way, b, (b == 3), 3'b000});
    endfunction

    function automatic void push_resp(input int way, input logic wr, input logic [2:0] plru);
        exp_q.push_back('{EV_RESP, way, 1, wr, plru});
    endfunction

    // Drive one CPU request, act as pmem and tag array, and score every event.
    task automatic run_txn(input logic rd, input logic wr, input logic [3:0] hit,
                           input logic [3:0] valid, input logic [3:0] dirty,
                           input logic [2:0] plru, input int drop_at,
                           output int resp_cyc, output int pmem_cyc);
        logic [3:0] cur_hit;
        int         tail;
        ev_t        obs, ex;
        bit         got;
        cur_hit  = hit;
        tail     = 0;
        resp_cyc = 0;
        pmem_cyc = 0;
        valid_way = valid;
        dirty_way = dirty;
        plru_in   = plru;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (exp_q.size() == 0 || cyc >= drop_at) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end else begin
                mem_read  = rd;
                mem_write = wr;
            end
            hit_way   = cur_hit;
            pmem_resp = (pmem_read || pmem_write) && ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (pmem_read || pmem_write) pmem_cyc++;
            got = 1'b1;
            if (pmem_write && pmem_resp)
                obs = '{EV_WB, int'(way_sel), int'(beat_cnt), wb_addr_sel, 3'b000};
            else if (load_data && data_in_sel)
                obs = '{EV_FILL, int'(way_sel), int'(beat_cnt),
                        load_tag & load_valid & clr_dirty, 3'b000};
            else if (clr_dirty)
                obs = '{EV_CLR, int'(way_sel), 0, 1'b0, 3'b000};
            else if (mem_resp)
                obs = '{EV_RESP, int'(way_sel), int'(load_plru),
                        set_dirty & load_data & ~data_in_sel, plru_out};
            else
                got = 1'b0;
            if (got) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event kind=%0d way=%0d at cycle %0d, none expected",
                             obs.kind, obs.way, cyc);
                end else begin
                    ex = exp_q.pop_front();
                    if (obs.kind != ex.kind || obs.way != ex.way || obs.aux != ex.aux ||
                        obs.flag !== ex.flag || obs.plru !== ex.plru) begin
                        errors++;
                        $display("FAIL event kind/way/aux/flag/plru got %0d/%0d/%0d/%0b/%03b expected %0d/%0d/%0d/%0b/%03b",
                                 obs.kind, obs.way, obs.aux, obs.flag, obs.plru,
                                 ex.kind, ex.way, ex.aux, ex.flag, ex.plru);
                    end
                end
                if (obs.kind == EV_FILL && obs.flag) cur_hit = 4'b0001 << obs.way;
                if (obs.kind == EV_RESP) resp_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                tail++;
                if (tail >= 3) break;
            end
        end
        pmem_resp = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit_way   = 4'b0000;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL txn_timeout pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; hit_way = 4'b0000;
        valid_way = 4'b0000; dirty_way = 4'b0000; plru_in = 3'b000; pmem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h expected 0", all_out); end
        mem_read = 1'b1; hit_way = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_hold got %h expected 0", all_out); end
        @(posedge clk); #1;
        mem_read = 1'b0; hit_way = 4'b0000; rst = 1'b1;
    endtask

    task automatic test_idle_conflict();
        mem_read = 1'b1; mem_write = 1'b1; hit_way = 4'b0001; valid_way = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            pmem_resp = (i == 1);
            @(negedge clk);
            checks++;
            if (all_out !== '0) begin errors++; $display("FAIL both_requests cyc %0d got %h expected 0", i, all_out); end
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0; hit_way = 4'b0000; pmem_resp = 1'b0;
    endtask

    task automatic test_read_hit();
        int rc, pc;
        push_resp(2, 1'b0, 3'b100);
        run_txn(1'b1, 1'b0, 4'b0100, 4'b1111, 4'b0000, 3'b000, 999, rc, pc);
        checks++;
        if (rc != 2) begin errors++; $display("FAIL hit_latency got %0d expected 2", rc); end
        checks++;
        if (pc != 0) begin errors++; $display("FAIL hit_pmem_cycles got %0d expected 0", pc); end
    endtask

    task automatic test_plru_hits();
        int rc, pc;
        push_resp(0, 1'b0, 3'b011);
        run_txn(1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 999, rc, pc);
        push_resp(3, 1'b1, 3'b010);
        run_txn(1'b0, 1'b1, 4'b1000, 4'b1111, 4'b1111, 3'b111, 999, rc, pc);
        push_resp(1, 1'b0, 3'b001);
        run_txn(1'b1, 1'b0, 4'b0110, 4'b1111, 4'b0000, 3'b000, 999, rc, pc);
    endtask

    task automatic test_write_miss();
        int rc, pc;
        push_fill(2);
        push_resp(2, 1'b1, 3'b100);
        run_txn(1'b0, 1'b1, 4'b0000, 4'b1011, 4'b0000, 3'b000, 999, rc, pc);
    endtask

    task automatic test_dirty_miss();
        int rc, pc;
        push_wb(0);
        push_fill(0);
        push_resp(0, 1'b0, 3'b011);
        run_txn(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0001, 3'b000, 999, rc, pc);
    endtask

    task automatic test_drop_mid_miss();
        int rc, pc;
        push_fill(3);
        run_txn(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b101, 4, rc, pc);
        checks++;
        if (rc != 0) begin errors++; $display("FAIL drop_no_resp got cycle %0d expected 0", rc); end
    endtask

    task automatic test_reset_mid_alloc();
        int rc, pc;
        bit hit_pt;
        valid_way = 4'b1011; dirty_way = 4'b0000; plru_in = 3'b000; hit_way = 4'b0000;
        mem_write = 1'b1; mem_read = 1'b0;
        hit_pt = 1'b0;
        for (int cyc = 0; cyc < 40 && !hit_pt; cyc++) begin
            pmem_resp = pmem_read || pmem_write;
            @(negedge clk);
            if (pmem_read && beat_cnt == 2'd2) begin
                hit_pt = 1'b1;
                #2 rst = 1'b0;
                #1;
                checks++;
                if (pmem_read !== 1'b0 || beat_cnt !== 2'd0 || all_out !== '0) begin
                    errors++;
                    $display("FAIL reset_mid_alloc pmem_read=%0b beat=%0d out=%h expected 0/0/0",
                             pmem_read, beat_cnt, all_out);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!hit_pt) begin errors++; $display("FAIL alloc_beat2_timeout got none expected beat 2"); end
        mem_write = 1'b0; pmem_resp = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        push_resp(1, 1'b0, 3'b001);
        run_txn(1'b1, 1'b0, 4'b0010, 4'b1111, 4'b0000, 3'b000, 999, rc, pc);
        checks++;
        if (rc != 2 || pc != 0) begin
            errors++;
            $display("FAIL post_reset_hit latency/pmem got %0d/%0d expected 2/0", rc, pc);
        end
    endtask

    task automatic test_perf();
        int rc, pc;
        logic [31:0] eh, em, ew;
`ifdef CACHE_CTRL_PERF_EN
        eh = 32'd4; em = 32'd1; ew = 32'd1;
`else
        eh = 32'd0; em = 32'd0; ew = 32'd0;
`endif
        rst = 1'b0;
        #2;
        checks++;
        if ({hit_count, miss_count, wb_count} !== 96'h0) begin
            errors++;
            $display("FAIL perf_reset got %0d/%0d/%0d expected 0/0/0", hit_count, miss_count, wb_count);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        push_resp(0, 1'b0, 3'b011);
        run_txn(1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 999, rc, pc);
        push_resp(1, 1'b1, 3'b001);
        run_txn(1'b0, 1'b1, 4'b0010, 4'b1111, 4'b0000, 3'b000, 999, rc, pc);
        push_resp(3, 1'b0, 3'b010);
        run_txn(1'b1, 1'b0, 4'b1000, 4'b1111, 4'b0000, 3'b111, 999, rc, pc);
        push_wb(3);
        push_fill(3);
        push_resp(3, 1'b0, 3'b010);
        run_txn(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1000, 3'b111, 999, rc, pc);
        checks++;
        if (hit_count !== eh) begin errors++; $display("FAIL hit_count got %0d expected %0d", hit_count, eh); end
        checks++;
        if (miss_count !== em) begin errors++; $display("FAIL miss_count got %0d expected %0d", miss_count, em); end
        checks++;
        if (wb_count !== ew) begin errors++; $display("FAIL wb_count got %0d expected %0d", wb_count, ew); end
    endtask

    initial begin
        test_reset();
        test_idle_conflict();
        test_read_hit();
        test_plru_hits();
        test_write_miss();
        test_dirty_miss();
        test_drop_mid_miss();
        test_reset_mid_alloc();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
